ecdhe_keygen_bank: RTL and testbench



---
 rtl/ecdhe_keygen_bank.sv | 223 ++++++++++++++++++++++
 tb/tb_ecdhe_keygen_bank.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecdhe_keygen_bank.sv
// ecdhe_keygen_bank
// -----------------------------------------------------------------------------
// Multi-slot ECDHE key-pair generator. A keygen request carries a destination
// slot and a 32-bit seed. The seed is expanded into a KEY_W-bit private key,
// one 32-bit word per cycle (GEN). A fixed-latency stand-in for point
// multiplication follows (MULT). The key pair is then written into the
// selected slot (STORE). Stored pairs are read back through a registered read
// port with one cycle of latency.
//
// Optional feature: define KEYGEN_ZEROIZE_EN to add the zeroize and
// zeroize_slot inputs. These clear a slot, and abort generation into that slot.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready keygen request handshake; req_slot, req_seed payload
//   busy                high in any state other than IDLE
//   done, done_slot     one-cycle pulse when a pair is stored, and its slot
//   error               one-cycle pulse after a request to an out-of-range slot
//   slot_valid          per-slot "holds a complete pair" flags
//   rd_en, rd_slot      read strobe and address
//   rd_valid            registered; addressed slot was valid when rd_en was high
//   rd_public_key       {X, Y}, with X in the upper half
//   rd_private_key      private scalar
//   zeroize, zeroize_slot  (KEYGEN_ZEROIZE_EN only) slot clear strobe/address
//   fsm_state           debug view of the controller state (IDLE=0, GEN=1,
//                       MULT=2, STORE=3)
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high and req_slot < NUM_SLOTS. req_ready is high only in IDLE.
// Nothing is queued, so the requester holds req_valid until req_ready is seen.
// In IDLE, a request to an out-of-range slot is dropped and pulses error instead.
// -----------------------------------------------------------------------------
module ecdhe_keygen_bank #(
    parameter int KEY_W     = 256,
    parameter int NUM_SLOTS = 4,
    parameter int LATENCY   = 20,
    localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SLOT_W-1:0]      req_slot,
    input  logic [31:0]            req_seed,
    output logic                   busy,
    output logic                   done,
    output logic [SLOT_W-1:0]      done_slot,
    output logic                   error,
    output logic [NUM_SLOTS-1:0]   slot_valid,
    input  logic                   rd_en,
    input  logic [SLOT_W-1:0]      rd_slot,
    output logic                   rd_valid,
    output logic [2*KEY_W-1:0]     rd_public_key,
    output logic [KEY_W-1:0]       rd_private_key,
`ifdef KEYGEN_ZEROIZE_EN
    input  logic                   zeroize,
    input  logic [SLOT_W-1:0]      zeroize_slot,
`endif
    output logic [1:0]             fsm_state
);

    localparam int N        = KEY_W / 32;
    localparam int GEN_CW   = $clog2(N);
    localparam int MULT_CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] GOLDEN = 32'h9E3779B9;
    localparam logic [KEY_W-1:0] X_PAD = {N{32'hA5A5A5A5}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        MULT  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [GEN_CW-1:0]    gen_cnt;
    logic [MULT_CW-1:0]   mult_cnt;
    logic [31:0]          word_q;
    logic [KEY_W-1:0]     priv_q;
    logic [SLOT_W-1:0]    cur_slot;

    logic [KEY_W-1:0]     priv_mem [NUM_SLOTS];
    logic [2*KEY_W-1:0]   pub_mem  [NUM_SLOTS];

    logic                 req_slot_ok;
    logic                 rd_slot_ok;
    logic                 rd_hit;
    logic                 gen_last;
    logic                 accept;
    logic                 reject;
    logic                 store_en;
    logic                 zero_hit;
    logic [SLOT_W-1:0]    zero_slot;
    logic                 zero_abort;

    // Range checks are done at 32 bits so that a non-power-of-2 NUM_SLOTS
    // rejects the unused encodings of the slot field.
    assign req_slot_ok = (32'(req_slot) < 32'(NUM_SLOTS));
    assign rd_slot_ok  = (32'(rd_slot) < 32'(NUM_SLOTS));
    assign rd_hit      = rd_slot_ok && slot_valid[rd_slot];
    assign gen_last    = (gen_cnt == GEN_CW'(N - 1));

`ifdef KEYGEN_ZEROIZE_EN
    assign zero_hit  = zeroize && (32'(zeroize_slot) < 32'(NUM_SLOTS));
    assign zero_slot = zeroize_slot;
`else
    assign zero_hit  = 1'b0;
    assign zero_slot = '0;
`endif

    // Zeroizing the slot under generation abandons that generation.
    assign zero_abort = zero_hit && (state_q != IDLE) && (zero_slot == cur_slot);

    assign fsm_state = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && req_slot_ok) state_d = GEN;
            GEN:     if (gen_last) state_d = MULT;
            MULT:    if (mult_cnt == '0) state_d = STORE;
            STORE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (zero_abort) begin
            state_d = IDLE;
        end
    end

    // Output / control decode
    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        accept    = (state_q == IDLE) && req_valid && req_slot_ok;
        reject    = (state_q == IDLE) && req_valid && !req_slot_ok;
        store_en  = (state_q == STORE) && !zero_abort;
    end

    // Datapath, slot storage and read port
    always_ff @(posedge clk) begin
        if (reset) begin
            gen_cnt        <= '0;
            mult_cnt       <= '0;
            word_q         <= '0;
            priv_q         <= '0;
            cur_slot       <= '0;
            done           <= 1'b0;
            done_slot      <= '0;
            error          <= 1'b0;
            slot_valid     <= '0;
            rd_valid       <= 1'b0;
            rd_public_key  <= '0;
            rd_private_key <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                priv_mem[i] <= '0;
                pub_mem[i]  <= '0;
            end
        end else begin
            error <= reject;
            done  <= store_en;

            if (accept) begin
                cur_slot             <= req_slot;
                word_q               <= (req_seed == 32'd0) ? 32'd1 : req_seed;
                gen_cnt              <= '0;
                slot_valid[req_slot] <= 1'b0;
            end

            // Words enter at the top and shift down, so after N cycles word 0
            // sits in the LSBs. word_q runs the seed' + i*GOLDEN sequence.
            if (state_q == GEN) begin
                priv_q  <= {word_q, priv_q[KEY_W-1:32]};
                word_q  <= word_q + GOLDEN;
                gen_cnt <= gen_cnt + 1'b1;
                if (gen_last) begin
                    mult_cnt <= MULT_CW'(LATENCY - 1);
                end
            end

            if ((state_q == MULT) && (mult_cnt != '0)) begin
                mult_cnt <= mult_cnt - 1'b1;
            end

            if (store_en) begin
                priv_mem[cur_slot]   <= priv_q;
                pub_mem[cur_slot]    <= {priv_q ^ X_PAD, ~priv_q};
                slot_valid[cur_slot] <= 1'b1;
                done_slot            <= cur_slot;
            end

            // Placed after the store so a clear of the same slot wins.
            if (zero_hit) begin
                priv_mem[zero_slot]   <= '0;
                pub_mem[zero_slot]    <= '0;
                slot_valid[zero_slot] <= 1'b0;
            end
            if (zero_abort) begin
                priv_q <= '0;
            end

            // Reads see the storage as it was before this edge's writes.
            if (rd_en) begin
                rd_valid       <= rd_hit;
                rd_private_key <= rd_hit ? priv_mem[rd_slot] : '0;
                rd_public_key  <= rd_hit ? pub_mem[rd_slot] : '0;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ecdhe_keygen_bank.sv
// Testbench for ecdhe_keygen_bank. It builds a 3-slot bank, which gives a
// non-power-of-2 slot count with one out-of-range encoding. Expected keys come
// from a behavioural model of slots (arrays) and a queue of pending reads.
module tb_ecdhe_keygen_bank;

    localparam int KEY_W     = 256;
    localparam int NUM_SLOTS = 3;
    localparam int LATENCY   = 20;
    localparam int SLOT_W    = 2;
    localparam int N         = KEY_W / 32;
    localparam int LAT       = N + LATENCY + 1;
    localparam int BOUND     = 200;
    localparam logic [31:0] GOLDEN = 32'h9E3779B9;

    // ---------------- clock / reset ----------------
    logic                  clk;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic [SLOT_W-1:0]     req_slot;
    logic [31:0]           req_seed;
    logic                  busy;
    logic                  done;
    logic [SLOT_W-1:0]     done_slot;
    logic                  error;
    logic [NUM_SLOTS-1:0]  slot_valid;
    logic                  rd_en;
    logic [SLOT_W-1:0]     rd_slot;
    logic                  rd_valid;
    logic [2*KEY_W-1:0]    rd_public_key;
    logic [KEY_W-1:0]      rd_private_key;
    logic [1:0]            fsm_state;
`ifdef KEYGEN_ZEROIZE_EN
    logic                  zeroize;
    logic [SLOT_W-1:0]     zeroize_slot;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ecdhe_keygen_bank #(
        .KEY_W     (KEY_W),
        .NUM_SLOTS (NUM_SLOTS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_slot       (req_slot),
        .req_seed       (req_seed),
        .busy           (busy),
        .done           (done),
        .done_slot      (done_slot),
        .error          (error),
        .slot_valid     (slot_valid),
        .rd_en          (rd_en),
        .rd_slot        (rd_slot),
        .rd_valid       (rd_valid),
        .rd_public_key  (rd_public_key),
        .rd_private_key (rd_private_key),
`ifdef KEYGEN_ZEROIZE_EN
        .zeroize        (zeroize),
        .zeroize_slot   (zeroize_slot),
`endif
        .fsm_state      (fsm_state)
    );

    // ---------------- reference model ----------------
    logic [KEY_W-1:0]     m_priv [4];
    logic [3:0]           m_valid;
    logic [KEY_W-1:0]     last_priv;
    logic [2*KEY_W-1:0]   last_pub;
    logic [3*KEY_W:0]     exp_q[$];   // {valid, public, private}
    int total;
    int bad;

    function automatic logic [KEY_W-1:0] gen_priv(input logic [31:0] seed);
        logic [KEY_W-1:0] p;
        logic [31:0] s;
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < N; i++) begin
            p[i*32 +: 32] = s + 32'(i) * GOLDEN;
        end
        return p;
    endfunction

    function automatic logic [2*KEY_W-1:0] pub_of(input logic [KEY_W-1:0] p);
        logic [KEY_W-1:0] pad;
        for (int i = 0; i < N; i++) begin
            pad[i*32 +: 32] = 32'hA5A5A5A5;
        end
        return {p ^ pad, ~p};
    endfunction

    function automatic logic [3*KEY_W:0] expect_for(input int slot);
        if (slot < NUM_SLOTS && m_valid[slot]) begin
            return {1'b1, pub_of(m_priv[slot]), m_priv[slot]};
        end
        return '0;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [2*KEY_W-1:0] got,
                         input logic [2*KEY_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with an optional read; checks the read result (or the idle
    // behaviour of the read port) after the edge.
    task automatic rd_cycle(input bit issue, input int slot);
        logic [3*KEY_W:0] e;
        if (issue) begin
            rd_en   = 1'b1;
            rd_slot = SLOT_W'(slot);
            exp_q.push_back(expect_for(slot));
        end
        step();
        rd_en = 1'b0;
        if (issue) begin
            e = exp_q.pop_front();
            check("rd_valid", rd_valid, e[3*KEY_W]);
            check("rd_pub", rd_public_key, e[3*KEY_W-1:KEY_W]);
            check("rd_priv", rd_private_key, e[KEY_W-1:0]);
            last_pub  = e[3*KEY_W-1:KEY_W];
            last_priv = e[KEY_W-1:0];
        end else begin
            check("rd_idle_valid", rd_valid, 0);
            check("rd_hold_priv", rd_private_key, last_priv);
            check("rd_hold_pub", rd_public_key, last_pub);
        end
    endtask

    task automatic rand_cycle();
        rd_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    endtask

    task automatic start_req(input int slot, input logic [31:0] seed);
        req_valid = 1'b1;
        req_slot  = SLOT_W'(slot);
        req_seed  = seed;
        check("req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
        m_valid[slot] = 1'b0;
        check("slot_valid_clr", slot_valid, m_valid[2:0]);
        check("busy_start", busy, 1);
    endtask

    task automatic wait_done(input bit held, output int k);
        k = 0;
        while (k < BOUND && done !== 1'b1) begin
            check("busy_run", busy, 1);
            if (held) check("held_not_ready", req_ready, 0);
            rand_cycle();
            k++;
        end
    endtask

    task automatic finish_done(input int slot, input logic [31:0] seed);
        check("done_slot", done_slot, slot);
        m_priv[slot]  = gen_priv(seed);
        m_valid[slot] = 1'b1;
        check("slot_valid_set", slot_valid, m_valid[2:0]);
    endtask

    task automatic gen_run(input int slot, input logic [31:0] seed);
        int k;
        start_req(slot, seed);
        wait_done(1'b0, k);
        check("latency", k, LAT);
        if (done === 1'b1) finish_done(slot, seed);
        rand_cycle();
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic [31:0] s;
        total     = 0;
        bad       = 0;
        m_valid   = '0;
        last_priv = '0;
        last_pub  = '0;
        for (int i = 0; i < 4; i++) m_priv[i] = '0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_slot  = '0;
        req_seed  = '0;
        rd_en     = 1'b0;
        rd_slot   = '0;
`ifdef KEYGEN_ZEROIZE_EN
        zeroize      = 1'b0;
        zeroize_slot = '0;
`endif
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_slot_valid", slot_valid, 0);
        rd_cycle(1'b1, 0);

        // seed 0 into slot 2, with known first words
        gen_run(2, 32'd0);
        rd_cycle(1'b1, 2);
        check("priv_w0", rd_private_key[31:0], 32'h00000001);
        check("priv_w1", rd_private_key[63:32], 32'h9E3779BA);
        check("y_w0", rd_public_key[31:0], 32'hFFFFFFFE);
        check("x_w0", rd_public_key[KEY_W+31:KEY_W], 32'hA5A5A5A4);

        // A request held while busy is taken only after the current one finishes
        s = $urandom;
        start_req(2, s);
        for (int i = 0; i < 2; i++) rand_cycle();
        req_valid = 1'b1;
        req_slot  = 2'd1;
        req_seed  = 32'h12345678;
        wait_done(1'b1, k);
        check("latency_first", k, LAT - 2);
        if (done === 1'b1) finish_done(2, s);
        check("held_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        m_valid[1] = 1'b0;
        check("held_accept_busy", busy, 1);
        check("first_done_pulse", done, 0);
        wait_done(1'b0, k);
        check("latency_held", k, LAT);
        if (done === 1'b1) finish_done(1, 32'h12345678);
        rd_cycle(1'b1, 2);
        rd_cycle(1'b1, 1);

        // Out-of-range request slot
        req_valid = 1'b1;
        req_slot  = 2'd3;
        req_seed  = $urandom;
        step();
        req_valid = 1'b0;
        check("err_pulse", error, 1);
        check("err_busy", busy, 0);
        check("err_ready", req_ready, 1);
        check("err_slot_valid", slot_valid, m_valid[2:0]);
        rd_cycle(1'b1, 3);
        check("err_pulse_end", error, 0);

        // Random keygens with random reads interleaved
        for (int r = 0; r < 6; r++) begin
            gen_run(int'($urandom_range(0, NUM_SLOTS - 1)), $urandom);
        end

        // Overwrite of a valid slot, then reset mid-generation
        gen_run(2, $urandom);
        start_req(2, $urandom);
        rd_cycle(1'b1, 2);
        for (int i = 0; i < 8; i++) begin
            rand_cycle();
            check("no_done_gen", done, 0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_valid   = '0;
        last_priv = '0;
        last_pub  = '0;
        check("rst2_slot_valid", slot_valid, 0);
        check("rst2_busy", busy, 0);
        for (int i = 0; i < LAT + 5; i++) begin
            rand_cycle();
            check("rst2_no_done", done, 0);
        end
        for (int i = 0; i < NUM_SLOTS; i++) rd_cycle(1'b1, i);

`ifdef KEYGEN_ZEROIZE_EN
        // Zeroize the slot under generation while in MULT
        gen_run(1, $urandom);
        start_req(0, $urandom);
        for (int i = 0; i < N + 3; i++) rand_cycle();
        zeroize      = 1'b1;
        zeroize_slot = 2'd0;
        step();
        zeroize = 1'b0;
        m_valid[0] = 1'b0;
        check("zero_busy", busy, 0);
        check("zero_slot_valid", slot_valid, m_valid[2:0]);
        for (int i = 0; i < LAT; i++) begin
            rand_cycle();
            check("zero_no_done", done, 0);
        end
        rd_cycle(1'b1, 0);
        rd_cycle(1'b1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
